evt_dc_src: RTL and testbench

EVT_DC_SRC -- requirements
Module: evt_dc_src

---
 rtl/evt_dc_pkg.sv | 31 +++
 rtl/evt_dc_sync.sv | 26 ++
 rtl/evt_dc_src.sv | 99 +++++++++
 tb/tb_evt_dc_src.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/evt_dc_pkg.sv
// rtl/evt_dc_pkg.sv - shared constants and one-hot helpers for the event dual-clock buffer
package evt_dc_pkg;

    localparam int DEF_BUFFER_DEPTH = 8;
    localparam int DEF_EVNT_WIDTH   = 8;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int MAX_DEPTH        = 16;

    function automatic logic [3:0] onehot_to_idx(input logic [MAX_DEPTH-1:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

    // Rotate left by one within the low 'depth' bits; bits above depth stay zero.
    function automatic logic [MAX_DEPTH-1:0] rotl1(input logic [MAX_DEPTH-1:0] v, input int depth);
        logic [MAX_DEPTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            if (i == depth - 1) r[0] = v[i];
        end
        for (int i = 0; i < MAX_DEPTH - 1; i++) begin
            if (i < depth - 1) r[i+1] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/evt_dc_sync.sv
// rtl/evt_dc_sync.sv - multi-stage flop-bank synchroniser with async reset to RESET_VAL
module evt_dc_sync #(
    parameter int               STAGES    = 2,
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] bank [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) bank[i] <= RESET_VAL;
        end else begin
            bank[0] <= d;
            for (int i = 1; i < STAGES; i++) bank[i] <= bank[i-1];
        end
    end

    assign q = bank[STAGES-1];

endmodule

// File: rtl/evt_dc_src.sv
// rtl/evt_dc_src.sv - source side of a token-ring event CDC buffer; EVT_DC_SRC_STALL_CNT_EN enables the stall counter
module evt_dc_src
    import evt_dc_pkg::*;
#(
    parameter int BUFFER_DEPTH = DEF_BUFFER_DEPTH,
    parameter int EVNT_WIDTH   = DEF_EVNT_WIDTH,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               evt_valid_i,
    input  logic [EVNT_WIDTH-1:0]              evt_data_i,
    output logic                               evt_ready_o,
    output logic [BUFFER_DEPTH-1:0]            writetoken_o,
    input  logic [BUFFER_DEPTH-1:0]            readpointer_i,
    output logic [BUFFER_DEPTH*EVNT_WIDTH-1:0] data_async_o,
    output logic [$clog2(BUFFER_DEPTH)-1:0]    occupancy_o,
    input  logic                               stall_clr_i,
    output logic [15:0]                        stall_cnt_o
);

    localparam int AW = $clog2(BUFFER_DEPTH);

    logic [BUFFER_DEPTH-1:0] rp_raw;
    logic [BUFFER_DEPTH-1:0] rp_sync;
    logic [MAX_DEPTH-1:0]    wt_wide;
    logic [MAX_DEPTH-1:0]    rp_wide;
    logic [MAX_DEPTH-1:0]    wt_rot;
    logic                    full;
    logic                    push;

    evt_dc_sync #(
        .STAGES    (SYNC_STAGES),
        .WIDTH     (BUFFER_DEPTH),
        .RESET_VAL (BUFFER_DEPTH'(1))
    ) u_rp_sync (
        .clk (clk_i),
        .rst (rst_i),
        .d   (readpointer_i),
        .q   (rp_raw)
    );

    // Capture only one-hot values so a pointer caught mid-transition never reaches the full logic.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rp_sync <= BUFFER_DEPTH'(1);
        end else if ($onehot(rp_raw)) begin
            rp_sync <= rp_raw;
        end
    end

    assign wt_wide     = MAX_DEPTH'(writetoken_o);
    assign rp_wide     = MAX_DEPTH'(rp_sync);
    assign wt_rot      = rotl1(wt_wide, BUFFER_DEPTH);
    assign full        = |(wt_rot & rp_wide);
    assign evt_ready_o = ~full;
    assign push        = evt_valid_i & evt_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            writetoken_o <= BUFFER_DEPTH'(1);
            data_async_o <= '0;
        end else if (push) begin
            writetoken_o <= wt_rot[BUFFER_DEPTH-1:0];
            for (int k = 0; k < BUFFER_DEPTH; k++) begin
                if (writetoken_o[k]) data_async_o[k*EVNT_WIDTH +: EVNT_WIDTH] <= evt_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            occupancy_o <= '0;
        end else begin
            occupancy_o <= AW'(onehot_to_idx(wt_wide) - onehot_to_idx(rp_wide));
        end
    end

`ifdef EVT_DC_SRC_STALL_CNT_EN
    logic [15:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else if (stall_clr_i) begin
            stall_q <= '0;
        end else if (evt_valid_i && !evt_ready_o && stall_q != 16'hFFFF) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    logic unused_stall_clr;
    assign unused_stall_clr = stall_clr_i;
    assign stall_cnt_o      = 16'h0000;
`endif

endmodule

// File: tb/tb_evt_dc_src.sv
// tb/tb_evt_dc_src.sv - directed self-checking bench for evt_dc_src
module tb_evt_dc_src;

    logic        clk;
    logic        rst;
    logic        evt_valid;
    logic [7:0]  evt_data;
    logic        evt_ready;
    logic [7:0]  writetoken;
    logic [7:0]  readpointer;
    logic [63:0] data_async;
    logic [2:0]  occupancy;
    logic        stall_clr;
    logic [15:0] stall_cnt;

    int total = 0;
    int bad   = 0;
    int accepts;

    evt_dc_src #(
        .BUFFER_DEPTH (8),
        .EVNT_WIDTH   (8),
        .SYNC_STAGES  (2)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .evt_valid_i   (evt_valid),
        .evt_data_i    (evt_data),
        .evt_ready_o   (evt_ready),
        .writetoken_o  (writetoken),
        .readpointer_i (readpointer),
        .data_async_o  (data_async),
        .occupancy_o   (occupancy),
        .stall_clr_i   (stall_clr),
        .stall_cnt_o   (stall_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] slot(input int k);
        return data_async[k*8 +: 8];
    endfunction

    initial begin
        rst         = 1'b1;
        evt_valid   = 1'b0;
        evt_data    = 8'h00;
        readpointer = 8'h01;
        stall_clr   = 1'b0;
        #1;
        chk("rst_wt", writetoken, 8'h01);
        chk("rst_occ", occupancy, 3'd0);
        chk("rst_data", data_async, 64'h0);
        chk("rst_stall", stall_cnt, 16'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", evt_ready, 1'b1);

        // basic write
        evt_valid = 1'b1;
        evt_data  = 8'hA5;
        tick();
        evt_valid = 1'b0;
        chk("wr_wt", writetoken, 8'h02);
        chk("wr_slot0", slot(0), 8'hA5);
        chk("wr_occ_lag", occupancy, 3'd0);
        tick();
        chk("wr_occ", occupancy, 3'd1);

        // fill with valid held high
        accepts = 1;
        evt_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            evt_data = 8'h10 + 8'(accepts);
            if (evt_ready) accepts++;
            tick();
        end
        evt_valid = 1'b0;
        chk("fill_accepts", accepts, 7);
        chk("fill_wt", writetoken, 8'h80);
        chk("fill_ready", evt_ready, 1'b0);
        chk("fill_occ", occupancy, 3'd7);
        chk("fill_slot1", slot(1), 8'h11);
        chk("fill_slot6", slot(6), 8'h16);

        // stall counter
        stall_clr = 1'b1;
        tick();
        stall_clr = 1'b0;
        evt_valid = 1'b1;
        repeat (10) tick();
        evt_valid = 1'b0;
`ifdef EVT_DC_SRC_STALL_CNT_EN
        chk("stall_10", stall_cnt, 16'd10);
`else
        chk("stall_off", stall_cnt, 16'd0);
`endif
        stall_clr = 1'b1;
        evt_valid = 1'b1;
        tick();
        stall_clr = 1'b0;
        evt_valid = 1'b0;
        chk("stall_clr", stall_cnt, 16'd0);
        chk("stall_wt_hold", writetoken, 8'h80);

        // glitch 0x06 then release to 0x02
        readpointer = 8'h06;
        tick();
        chk("gl_ready1", evt_ready, 1'b0);
        readpointer = 8'h02;
        tick();
        chk("gl_ready2", evt_ready, 1'b0);
        tick();
        chk("gl_ready3", evt_ready, 1'b0);
        tick();
        chk("rel_ready", evt_ready, 1'b1);
        tick();
        chk("rel_occ", occupancy, 3'd6);

        // push into slot 7, token wraps
        evt_valid = 1'b1;
        evt_data  = 8'h77;
        tick();
        evt_valid = 1'b0;
        chk("wrap_wt", writetoken, 8'h01);
        chk("wrap_slot7", slot(7), 8'h77);
        chk("wrap_ready", evt_ready, 1'b0);
        tick();
        chk("wrap_occ", occupancy, 3'd7);

        // drain and push 3, then async reset between edges
        readpointer = 8'h01;
        repeat (3) tick();
        chk("drain_ready", evt_ready, 1'b1);
        tick();
        chk("drain_occ", occupancy, 3'd0);
        evt_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            evt_data = 8'h31 + 8'(i);
            tick();
        end
        evt_valid = 1'b0;
        chk("p3_wt", writetoken, 8'h08);
        chk("p3_slot2", slot(2), 8'h33);
        tick();
        chk("p3_occ", occupancy, 3'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_wt", writetoken, 8'h01);
        chk("arst_occ", occupancy, 3'd0);
        chk("arst_data", data_async, 64'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("post_ready", evt_ready, 1'b1);
        evt_valid = 1'b1;
        evt_data  = 8'h5A;
        tick();
        evt_valid = 1'b0;
        chk("post_wt", writetoken, 8'h02);
        chk("post_slot0", slot(0), 8'h5A);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
